// File: rtl/timer_pkg.sv
// Shared types, active-low segment patterns and BCD helpers for the BCD timer.
// bin_to_bcd is evaluated at elaboration for reset and wrap constants;
// bcd_to_bin is used at run time to range-check load values.
`timescale 1ns/1ps
package timer_pkg;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [6:0] seg7_t;

   // Widest supported counter; helpers work on this width and callers slice.
   localparam int MAX_DIGITS = 6;
   localparam int BCD_W_MAX  = 4 * MAX_DIGITS;

   // Active-low {g,f,e,d,c,b,a} patterns.
   localparam seg7_t SEG_0     = 7'b1000000;
   localparam seg7_t SEG_1     = 7'b1111001;
   localparam seg7_t SEG_2     = 7'b0100100;
   localparam seg7_t SEG_3     = 7'b0110000;
   localparam seg7_t SEG_4     = 7'b0011001;
   localparam seg7_t SEG_5     = 7'b0010010;
   localparam seg7_t SEG_6     = 7'b0000010;
   localparam seg7_t SEG_7     = 7'b1111000;
   localparam seg7_t SEG_8     = 7'b0000000;
   localparam seg7_t SEG_9     = 7'b0010000;
   localparam seg7_t SEG_BLANK = 7'b1111111;

   // Nibble to segment pattern; non-decimal nibbles show blank.
   function automatic seg7_t bcd_to_seg(input bcd_digit_t digit);
      case (digit)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // Binary to packed BCD, digit 0 in bits [3:0].
   function automatic logic [BCD_W_MAX-1:0] bin_to_bcd(input int unsigned value);
      logic [BCD_W_MAX-1:0] bcd;
      int unsigned          rest;
      bcd  = '0;
      rest = value;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         bcd[4*i +: 4] = 4'(rest % 32'd10);
         rest          = rest / 32'd10;
      end
      return bcd;
   endfunction

   // Packed BCD to binary; nibbles above 9 are weighted as-is (caller rejects them).
   function automatic int unsigned bcd_to_bin(input logic [BCD_W_MAX-1:0] bcd);
      int unsigned acc;
      acc = 0;
      for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
         acc = acc * 32'd10 + {28'd0, bcd[4*i +: 4]};
      end
      return acc;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment decoder, one per digit.
`timescale 1ns/1ps
module seg7_decoder
   import timer_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   // Pure table lookup; the timer registers the result.
   always_comb begin
      o_seg = bcd_to_seg(i_digit);
   end

endmodule

// File: rtl/bcd_timer_digits.sv
// Multi-digit BCD timer with wrap/borrow pulse, load, clear, pause and
// per-digit active-low 7-segment outputs, all registered.
// Optional build macro BCD_TIMER_LEADING_ZERO_BLANK_EN: blank leading zero
// digits above digit 0 on seg (count_bcd is not affected).
//
// Edge priority: clear > load > counted tick. A load, valid or not, swallows
// the tick in the same cycle. seg is decoded from the next count so it changes
// on the same edge as count_bcd.
`timescale 1ns/1ps
module bcd_timer_digits
   import timer_pkg::*;
#(
   parameter int DIGITS    = 2,
   parameter int MODULUS   = 60,
   parameter int RESET_VAL = 0
) (
   input  logic                  clock,
   input  logic                  RESET,
   input  logic                  tick,
   input  logic                  enable,
   input  logic                  up,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic                  carry_out,
   output logic                  load_err,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int W  = 4 * DIGITS;
   localparam int SW = 7 * DIGITS;

`ifdef BCD_TIMER_LEADING_ZERO_BLANK_EN
   localparam bit L_BLANK_EN = 1'b1;
`else
   localparam bit L_BLANK_EN = 1'b0;
`endif

   localparam int unsigned L_MOD = MODULUS;

   localparam logic [BCD_W_MAX-1:0] L_RESET_BCD_FULL = bin_to_bcd(RESET_VAL);
   localparam logic [BCD_W_MAX-1:0] L_MAX_BCD_FULL   = bin_to_bcd(MODULUS - 1);
   localparam logic [W-1:0]         L_RESET_BCD      = L_RESET_BCD_FULL[W-1:0];
   localparam logic [W-1:0]         L_MAX_BCD        = L_MAX_BCD_FULL[W-1:0];

   // Digits i >= 1 that are zero with only zeros above them; all-clear when blanking is off.
   function automatic logic [DIGITS-1:0] blank_mask(input logic [W-1:0] bcd);
      logic [DIGITS-1:0] mask;
      logic              leading;
      mask    = '0;
      leading = L_BLANK_EN;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (leading && (bcd[4*i +: 4] == 4'd0)) begin
            mask[i] = 1'b1;
         end else begin
            leading = 1'b0;
         end
      end
      return mask;
   endfunction

   // Full display image for a BCD value; used for the reset constant.
   function automatic logic [SW-1:0] seg_image(input logic [W-1:0] bcd);
      logic [SW-1:0]     img;
      logic [DIGITS-1:0] mask;
      img  = '0;
      mask = blank_mask(bcd);
      for (int i = 0; i < DIGITS; i++) begin
         img[7*i +: 7] = mask[i] ? SEG_BLANK : bcd_to_seg(bcd[4*i +: 4]);
      end
      return img;
   endfunction

   localparam logic [SW-1:0] L_RESET_SEG = seg_image(L_RESET_BCD);

   logic [W-1:0]      r_count;
   logic              r_carry;
   logic              r_err;
   logic [SW-1:0]     r_seg;

   logic [W-1:0]      w_inc;
   logic [W-1:0]      w_dec;
   logic              w_nibbles_ok;
   int unsigned       w_load_bin;
   logic              w_load_ok;
   logic [W-1:0]      w_next_count;
   logic              w_next_carry;
   logic              w_next_err;
   logic [SW-1:0]     w_dec_seg;
   logic [DIGITS-1:0] w_blank;
   logic [SW-1:0]     w_next_seg;

   // BCD increment: a 9 rolls to 0 and the carry ripples upward.
   always_comb begin
      logic w_chain;
      w_inc   = r_count;
      w_chain = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_chain) begin
            if (r_count[4*i +: 4] == 4'd9) begin
               w_inc[4*i +: 4] = 4'd0;
            end else begin
               w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
               w_chain         = 1'b0;
            end
         end
      end
   end

   // BCD decrement: a 0 rolls to 9 and the borrow ripples upward.
   always_comb begin
      logic w_chain;
      w_dec   = r_count;
      w_chain = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_chain) begin
            if (r_count[4*i +: 4] == 4'd0) begin
               w_dec[4*i +: 4] = 4'd9;
            end else begin
               w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
               w_chain         = 1'b0;
            end
         end
      end
   end

   // A load is accepted only if every nibble is decimal and the value is in range.
   always_comb begin
      w_nibbles_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) begin
            w_nibbles_ok = 1'b0;
         end
      end
      w_load_bin = bcd_to_bin(BCD_W_MAX'(load_val));
      w_load_ok  = w_nibbles_ok && (w_load_bin < L_MOD);
   end

   // Next count and pulses, applying clear > load > tick priority.
   always_comb begin
      w_next_count = r_count;
      w_next_carry = 1'b0;
      w_next_err   = 1'b0;
      if (clear) begin
         w_next_count = L_RESET_BCD;
      end else if (load) begin
         if (w_load_ok) begin
            w_next_count = load_val;
         end else begin
            w_next_err = 1'b1;
         end
      end else if (enable && tick) begin
         if (up) begin
            if (r_count == L_MAX_BCD) begin
               w_next_count = '0;
               w_next_carry = 1'b1;
            end else begin
               w_next_count = w_inc;
            end
         end else begin
            if (r_count == '0) begin
               w_next_count = L_MAX_BCD;
               w_next_carry = 1'b1;
            end else begin
               w_next_count = w_dec;
            end
         end
      end
   end

   // One decoder per digit, fed from the next count.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      seg7_decoder u_dec (
         .i_digit (w_next_count[4*gi +: 4]),
         .o_seg   (w_dec_seg[7*gi +: 7])
      );
   end

   // Apply leading-zero blanking (no-op unless the blanking macro is set).
   always_comb begin
      w_blank    = blank_mask(w_next_count);
      w_next_seg = w_dec_seg;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_blank[i]) begin
            w_next_seg[7*i +: 7] = SEG_BLANK;
         end
      end
   end

   // Output registers; reset forces the RESET_VAL image immediately.
   always_ff @(posedge clock or negedge RESET) begin
      if (!RESET) begin
         r_count <= L_RESET_BCD;
         r_carry <= 1'b0;
         r_err   <= 1'b0;
         r_seg   <= L_RESET_SEG;
      end else begin
         r_count <= w_next_count;
         r_carry <= w_next_carry;
         r_err   <= w_next_err;
         r_seg   <= w_next_seg;
      end
   end

   assign count_bcd = r_count;
   assign carry_out = r_carry;
   assign load_err  = r_err;
   assign seg       = r_seg;

endmodule

// File: doc/bcd_timer_digits.md
Name: bcd_timer_digits

Overview:
- Parametrised multi-digit BCD timer counter with per-digit active-low 7-segment outputs.
- Counts on a single-cycle tick enable and wraps at a configurable modulus; default is seconds 00..59.
- Emits a one-cycle carry/borrow pulse so instances chain (seconds -> minutes -> hours).
- Adds up/down counting, synchronous load, pause and clear.

Parameters:
- DIGITS, 2, number of BCD digits (1..6).
- MODULUS, 60, count range 0..MODULUS-1; legal range 2..10^DIGITS.
- RESET_VAL, 0, binary value restored on reset and on clear; must be < MODULUS.

Ports:
- clock  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- tick  in  1  count enable, one clock wide (1 Hz strobe or upstream carry_out).
- enable  in  1  1 = run, 0 = pause (ticks ignored).
- up  in  1  1 = count up, 0 = count down.
- clear  in  1  synchronous return to RESET_VAL.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
- count_bcd  out  4*DIGITS  current value in BCD, registered.
- carry_out  out  1  one-cycle pulse on wrap (up) or borrow (down).
- load_err  out  1  one-cycle pulse when a load is rejected.
- seg  out  7*DIGITS  per digit {g,f,e,d,c,b,a}, active-low; digit i is in seg[7*i+:7].

Behaviour:
- Reset (RESET=0, async): count_bcd = BCD(RESET_VAL); carry_out = 0; load_err = 0; seg = decode of RESET_VAL.
- All outputs are registered. seg updates on the same edge as count_bcd (zero extra latency).
- Per-edge priority: clear > load > counting.
  - clear=1: count = RESET_VAL; carry_out = 0; tick is ignored.
  - load=1, load_val valid: count = load_val; carry_out = 0; tick that cycle is ignored.
  - load_val is invalid if any nibble > 9 or its value >= MODULUS. Then count is unchanged, load_err = 1 for one cycle, and tick that cycle is also ignored.
  - Counting happens only when enable=1 and tick=1 and neither clear nor load is asserted.
- Counting up:
  - At value MODULUS-1, next value is 0 and carry_out = 1 for that cycle only.
  - Otherwise BCD increment, with a digit at 9 rolling to 0 and carrying to the next digit.
- Counting down:
  - At value 0, next value is MODULUS-1 and carry_out = 1.
  - Otherwise BCD decrement, with a digit at 0 rolling to 9 and borrowing from the next digit.
- carry_out is 0 in every cycle without a wrap. Back-to-back ticks at the wrap give one pulse per wrap.
- tick held high for N cycles counts N times; no edge detection is done.
- Changing `up` takes effect on the next counted tick; there is no internal state beyond the count.
- Reset asserted mid-count takes effect immediately and asynchronously. On release, the first tick counts from RESET_VAL.
- Decode, active-low {g..a}:
  - 0 -> 1000000
  - 1 -> 1111001
  - 2 -> 0100100
  - 3 -> 0110000
  - 4 -> 0011001
  - 5 -> 0010010
  - 6 -> 0000010
  - 7 -> 1111000
  - 8 -> 0000000
  - 9 -> 0010000
  - Any other nibble (unreachable) -> 1111111 (blank).

Optional Feature:
- Macro: BCD_TIMER_LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits in the upper positions drive 1111111 on seg. Digit 0 is never blanked, so value 5 with 3 digits shows "  5". count_bcd is unaffected.
- Undefined: every digit always shows its numeral, so value 5 with 3 digits shows "005".

Decomposition:
- Shared package timer_pkg:
  - bcd_digit_t (4-bit) and seg7_t (7-bit) typedefs.
  - Constants SEG_0..SEG_9 and SEG_BLANK.
  - Function bcd_to_seg.
  - Function bin_to_bcd, used at elaboration for RESET_VAL and MODULUS-1.
- One sub-module: seg7_decoder, combinational nibble-to-seg7_t, instantiated DIGITS times in a generate loop.

Test Plan:
- Default params, up=1, enable=1, 60 ticks from reset -> count 00,01..59,00.
  - carry_out pulses exactly once, on the tick 59 -> 00.
  - At 09 -> 10: digit0 seg = 1000000, digit1 seg = 1111001.
- up=0 from 00, one tick -> count 59, carry_out = 1.
  - Next tick -> 58, carry_out = 0.
- load=1 with load_val=0x42 and tick=1 in the same cycle -> count 42, no increment.
  - load_val=0x6A -> count unchanged, load_err pulse.
  - load_val=0x60 -> count unchanged, load_err pulse.
- DIGITS=3, MODULUS=24, count at 23, tick together with clear=1 -> count = RESET_VAL, carry_out = 0.
  - enable=0 with ticks -> count frozen.
- Reset asserted asynchronously between clock edges while at 37 -> outputs show 00 before the next edge.
  - After release, a single tick -> 01.
- With BCD_TIMER_LEADING_ZERO_BLANK_EN, DIGITS=3, value 7 -> digit2 and digit1 seg = 1111111, digit0 = 1111000.
  - Value 100 -> all three digits lit.
